// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_subtractor_pkg
// Shared definitions for the bit-serial subtractor:
//   state_t       - controller states (IDLE, RUN, DONE)
//   DEFAULT_WIDTH - default operand/result width in bits
// Optional feature macro used by the top level: SERIAL_SUBTRACTOR_OVF_EN
// -----------------------------------------------------------------------------
package serial_subtractor_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
// One-bit combinational full subtractor computing x - y - bin.
// Ports:
//   x    : in  - minuend bit
//   y    : in  - subtrahend bit
//   bin  : in  - borrow in from the less significant bit
//   d    : out - difference bit
//   bout : out - borrow out to the more significant bit
// -----------------------------------------------------------------------------
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = x ^ y ^ bin;
   // Borrow when the minuend bit is 0 against a 1, or the bits are equal
   // and a borrow is already pending.
   assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial unsigned subtractor: computes (a - b) mod 2^WIDTH one bit per
// clock, LSB first, using a single full_subtractor cell and a borrow flop.
// A start in IDLE captures the operands; WIDTH RUN cycles later the result
// is registered and DONE pulses for one cycle.
//
// Parameters:
//   WIDTH      - operand/result width, 2..32
// Ports:
//   clk        : in  - clock, rising edge
//   rst_n      : in  - synchronous active-low reset
//   start      : in  - begin a subtraction (only honoured in IDLE)
//   a, b       : in  - minuend / subtrahend, captured on the accepting edge
//   busy       : out - high while in RUN
//   done       : out - one-cycle pulse in DONE
//   diff       : out - (a - b) mod 2^WIDTH, held until the next DONE
//   borrow_out : out - unsigned a < b, held with diff
//   overflow   : out - signed overflow, only with SERIAL_SUBTRACTOR_OVF_EN
//
// Optional feature macro: SERIAL_SUBTRACTOR_OVF_EN adds the overflow output.
// -----------------------------------------------------------------------------
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   ,
   output logic             overflow
`endif
);

   localparam int                CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic             borrow;
   logic [CNT_W-1:0] cnt;
   logic             last_bit;
   logic             d_bit;
   logic             bout_bit;
   logic [WIDTH-1:0] res_nxt;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
   // Operand sign bits are shifted out during RUN, so keep a copy.
   logic             a_msb;
   logic             b_msb;
`endif

   full_subtractor u_fs (
      .x    (a_sr[0]),
      .y    (b_sr[0]),
      .bin  (borrow),
      .d    (d_bit),
      .bout (bout_bit)
   );

   assign last_bit = (cnt == LAST_BIT);
   // Difference bits enter at the MSB so that after WIDTH shifts the first
   // (LSB) result bit has reached position 0.
   assign res_nxt  = {d_bit, res_sr[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last_bit) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sr       <= '0;
         b_sr       <= '0;
         res_sr     <= '0;
         borrow     <= 1'b0;
         cnt        <= '0;
         diff       <= '0;
         borrow_out <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
         a_msb      <= 1'b0;
         b_msb      <= 1'b0;
         overflow   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr   <= a;
                  b_sr   <= b;
                  res_sr <= '0;
                  borrow <= 1'b0;
                  cnt    <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                  a_msb  <= a[WIDTH-1];
                  b_msb  <= b[WIDTH-1];
`endif
               end
            end
            RUN: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               res_sr <= res_nxt;
               borrow <= bout_bit;
               cnt    <= cnt + 1'b1;
               // Outputs are only published on the edge that enters DONE.
               if (last_bit) begin
                  diff       <= res_nxt;
                  borrow_out <= bout_bit;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                  overflow   <= (a_msb != b_msb) && (d_bit != a_msb);
`endif
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
// Self-checking bench for serial_subtractor. Two instances: WIDTH=8 for the
// directed vectors and corner sequences, WIDTH=4 for the exhaustive sweep.
// Expected results are queued when an operation is launched and compared
// when the matching done pulse appears.
// Honours SERIAL_SUBTRACTOR_OVF_EN (overflow port and checks).
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

   localparam int W8 = 8;
   localparam int W4 = 4;

   logic          clk = 1'b0;
   logic          rst_n;

   logic          start8;
   logic [W8-1:0] a8, b8;
   logic          busy8, done8, bor8;
   logic [W8-1:0] diff8;

   logic          start4;
   logic [W4-1:0] a4, b4;
   logic          busy4, done4, bor4;
   logic [W4-1:0] diff4;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic          ovf8, ovf4;
`endif

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(W8)) dut8 (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start8),
      .a          (a8),
      .b          (b8),
      .busy       (busy8),
      .done       (done8),
      .diff       (diff8),
      .borrow_out (bor8)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ,
      .overflow   (ovf8)
`endif
   );

   serial_subtractor #(.WIDTH(W4)) dut4 (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start4),
      .a          (a4),
      .b          (b4),
      .busy       (busy4),
      .done       (done4),
      .diff       (diff4),
      .borrow_out (bor4)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ,
      .overflow   (ovf4)
`endif
   );

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] diff;
      logic       bor;
      logic       ovf;
   } vec_t;

   typedef struct packed {
      logic [3:0] diff;
      logic       bor;
      logic       ovf;
   } exp4_t;

   vec_t  sb8[$];
   exp4_t sb4[$];

   int errors = 0;
   int checks = 0;
   int done_cnt8 = 0;
   int done_cnt4 = 0;
   int cyc = 0;
   int last_done4 = 0;
   bit have_last4 = 1'b0;
   logic [7:0] last_diff8 = 8'h00;
   logic       last_bor8  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard for the WIDTH=8 instance
   always @(negedge clk) begin
      vec_t e;
      if (rst_n === 1'b1 && done8 === 1'b1) begin
         done_cnt8++;
         if (sb8.size() == 0) begin
            check("done8_unexpected", 32'd1, 32'd0);
         end else begin
            e = sb8.pop_front();
            check("diff8", 32'(diff8), 32'(e.diff));
            check("borrow8", 32'(bor8), 32'(e.bor));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            check("overflow8", 32'(ovf8), 32'(e.ovf));
`endif
         end
      end
   end

   // Scoreboard and done spacing for the WIDTH=4 instance
   always @(negedge clk) begin
      exp4_t e;
      if (rst_n === 1'b1 && done4 === 1'b1) begin
         done_cnt4++;
         if (have_last4) check("done4_spacing", 32'(cyc - last_done4), 32'(W4 + 2));
         have_last4 = 1'b1;
         last_done4 = cyc;
         if (sb4.size() == 0) begin
            check("done4_unexpected", 32'd1, 32'd0);
         end else begin
            e = sb4.pop_front();
            check("diff4", 32'(diff4), 32'(e.diff));
            check("borrow4", 32'(bor4), 32'(e.bor));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            check("overflow4", 32'(ovf4), 32'(e.ovf));
`endif
         end
      end
   end

   task automatic wait_idle8();
      for (int i = 0; i < 20 && (busy8 !== 1'b0 || done8 !== 1'b0); i++) @(negedge clk);
      if (busy8 !== 1'b0 || done8 !== 1'b0) check("idle8_timeout", {busy8, done8}, 32'd0);
   endtask

   // Launch one operation on the 8-bit instance and check timing and hold.
   task automatic op8(input vec_t v);
      int busy_cycles;
      busy_cycles = 0;
      wait_idle8();
      a8 = v.a;
      b8 = v.b;
      start8 = 1'b1;
      sb8.push_back(v);
      @(negedge clk);
      start8 = 1'b0;
      a8 = ~v.a;
      b8 = v.b ^ 8'h5A;
      for (int i = 0; i < W8; i++) begin
         if (busy8 === 1'b1 && done8 === 1'b0) busy_cycles++;
         if (i == W8 / 2) begin
            check("diff8_hold", 32'(diff8), 32'(last_diff8));
            check("borrow8_hold", 32'(bor8), 32'(last_bor8));
         end
         @(negedge clk);
      end
      check("busy8_cycles", 32'(busy_cycles), 32'(W8));
      check("done8_latency", {busy8, done8}, 32'b01);
      last_diff8 = v.diff;
      last_bor8  = v.bor;
      @(negedge clk);
   endtask

   vec_t tbl[9];

   initial begin
      int dc;
      logic [4:0] r;
      logic [3:0] ea, eb;
      exp4_t e4;

      tbl[0] = '{a: 8'h05, b: 8'h03, diff: 8'h02, bor: 1'b0, ovf: 1'b0};
      tbl[1] = '{a: 8'h03, b: 8'h05, diff: 8'hFE, bor: 1'b1, ovf: 1'b0};
      tbl[2] = '{a: 8'h00, b: 8'hFF, diff: 8'h01, bor: 1'b1, ovf: 1'b0};
      tbl[3] = '{a: 8'h80, b: 8'h01, diff: 8'h7F, bor: 1'b0, ovf: 1'b1};
      tbl[4] = '{a: 8'h10, b: 8'h01, diff: 8'h0F, bor: 1'b0, ovf: 1'b0};
      tbl[5] = '{a: 8'hFF, b: 8'hFF, diff: 8'h00, bor: 1'b0, ovf: 1'b0};
      tbl[6] = '{a: 8'h7F, b: 8'h80, diff: 8'hFF, bor: 1'b1, ovf: 1'b1};
      tbl[7] = '{a: 8'h80, b: 8'h7F, diff: 8'h01, bor: 1'b0, ovf: 1'b1};
      tbl[8] = '{a: 8'hC3, b: 8'h3C, diff: 8'h87, bor: 1'b0, ovf: 1'b0};

      rst_n = 1'b0;
      start8 = 1'b0; a8 = '0; b8 = '0;
      start4 = 1'b0; a4 = '0; b4 = '0;
      repeat (3) @(negedge clk);

      check("rst_busy8", 32'(busy8), 32'd0);
      check("rst_done8", 32'(done8), 32'd0);
      check("rst_diff8", 32'(diff8), 32'd0);
      check("rst_borrow8", 32'(bor8), 32'd0);
      check("rst_busy4", 32'(busy4), 32'd0);
      check("rst_diff4", 32'(diff4), 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      check("rst_overflow8", 32'(ovf8), 32'd0);
`endif

      // Reset wins over a simultaneous start
      start8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
      @(negedge clk);
      check("rst_over_start_busy8", 32'(busy8), 32'd0);
      start8 = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_after_rst_busy8", 32'(busy8), 32'd0);

      for (int i = 0; i < 9; i++) op8(tbl[i]);

      // Start held high for a whole run with operands changed mid-run
      wait_idle8();
      dc = done_cnt8;
      a8 = 8'h05; b8 = 8'h03; start8 = 1'b1;
      sb8.push_back('{a: 8'h05, b: 8'h03, diff: 8'h02, bor: 1'b0, ovf: 1'b0});
      @(negedge clk);
      repeat (3) @(negedge clk);
      a8 = 8'hAA; b8 = 8'h11;
      repeat (5) @(negedge clk);
      check("hold_start_done", {busy8, done8}, 32'b01);
      sb8.push_back('{a: 8'hAA, b: 8'h11, diff: 8'h99, bor: 1'b0, ovf: 1'b0});
      @(negedge clk);
      check("hold_start_idle", {busy8, done8}, 32'b00);
      @(negedge clk);
      check("hold_start_rerun", {busy8, done8}, 32'b10);
      start8 = 1'b0;
      repeat (W8) @(negedge clk);
      check("rerun_done", {busy8, done8}, 32'b01);
      @(negedge clk);
      check("hold_start_done_count", 32'(done_cnt8 - dc), 32'd2);
      last_diff8 = 8'h99; last_bor8 = 1'b0;

      // Reset on RUN edge 4 aborts the operation
      wait_idle8();
      a8 = 8'h33; b8 = 8'h11; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_busy8", 32'(busy8), 32'd0);
      check("abort_done8", 32'(done8), 32'd0);
      check("abort_diff8", 32'(diff8), 32'd0);
      check("abort_borrow8", 32'(bor8), 32'd0);
      rst_n = 1'b1;
      last_diff8 = 8'h00; last_bor8 = 1'b0;
      dc = done_cnt8;
      repeat (W8 + 3) @(negedge clk);
      check("abort_no_done", 32'(done_cnt8 - dc), 32'd0);
      op8('{a: 8'h0A, b: 8'h0A, diff: 8'h00, bor: 1'b0, ovf: 1'b0});

      // Exhaustive WIDTH=4 sweep, back-to-back with start held high
      start4 = 1'b1;
      for (int i = 0; i < 256; i++) begin
         ea = 4'(i >> 4);
         eb = 4'(i);
         r  = {1'b0, ea} - {1'b0, eb};
         e4.diff = r[3:0];
         e4.bor  = r[4];
         e4.ovf  = (ea[3] != eb[3]) && (r[3] != ea[3]);
         sb4.push_back(e4);
         a4 = ea;
         b4 = eb;
         @(negedge clk);
         a4 = ~ea;
         b4 = ~eb;
         repeat (W4 + 1) @(negedge clk);
      end
      start4 = 1'b0;
      repeat (W4 + 3) @(negedge clk);
      check("exh4_done_count", 32'(done_cnt4), 32'd256);
      check("sb4_drained", 32'(sb4.size()), 32'd0);
      check("sb8_drained", 32'(sb8.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
